pkt_tx_framer: RTL and testbench
================================

// Module: pkt_tx_framer
// PURPOSE
//  Transmit-side counterpart of the RX packet capture path. Collects PAYLOAD_BYTES bytes
//  from the SPI slave byte output and frames them as preamble + sync word + payload.
//  Serializes the frame MSB-first on tx_out, one bit per bit_en strobe (bit-rate timing
//  from the shift-enable sync logic). Output feeds the RF modulator input in TX mode.
// PARAMETERS
//  PREAMBLE_BITS  16        alternating preamble length, first bit 1 (1010...)
//  SYNC_BITS      16        sync word length
//  SYNC_WORD      16'hD391  sync pattern, sent MSB-first
//  PAYLOAD_BYTES  8         payload bytes per frame (64-bit packet)
// PORTS
//  clk         in   1  system clock
//  rst         in   1  reset, asynchronous, active-high
//  bit_en      in   1  1-cycle bit-period strobe; tx_out advances only on this strobe
//  byte_in     in   8  payload byte from SPI slave
//  byte_valid  in   1  byte_in valid this cycle
//  byte_ready  out  1  buffer can accept a byte this cycle
//  tx_start    in   1  request to transmit the buffered frame
//  abort       in   1  synchronous cancel of fill/transmit
//  tx_out      out  1  serial frame output; idle level 0
//  tx_active   out  1  high from frame start until return to IDLE
//  tx_done     out  1  1-cycle pulse when a frame completes normally
//  buf_count   out  4  number of bytes buffered (0..PAYLOAD_BYTES)
//  overflow    out  1  1-cycle pulse when a byte is presented while byte_ready=0
// BEHAVIOUR
//  Reset: tx_out=0, tx_active=0, tx_done=0, overflow=0, buf_count=0, byte_ready=1,
//   state=IDLE. Reset mid-frame drops the frame immediately; the buffer is cleared.
//  Buffer: PAYLOAD_BYTES x 8 register array, written in order at index buf_count.
//  byte_ready = (state==IDLE) && (buf_count<PAYLOAD_BYTES).
//  byte_valid && byte_ready: store the byte; buf_count+1 at the next edge.
//  byte_valid && !byte_ready: drop the byte; overflow=1 for one cycle; buf_count unchanged.
//  FSM states: IDLE, PREAMBLE, SYNC, PAYLOAD, TAIL.
//  IDLE: tx_start with buf_count==PAYLOAD_BYTES (pre-write value) -> PREAMBLE next cycle.
//   tx_active=1 from that cycle. tx_start with a short buffer is ignored; no error flag.
//   tx_start and a completing byte write in the same cycle: start is ignored.
//  bit_en has no effect in IDLE; tx_out is held at 0.
//  Bit slots: tx_out is registered and updates at the edge that samples bit_en=1.
//  bit_cnt resets to 0 on each state entry.
//  PREAMBLE: bit i = ~i[0]. After PREAMBLE_BITS strobes -> SYNC.
//  SYNC: SYNC_WORD[SYNC_BITS-1-i]. After SYNC_BITS strobes -> PAYLOAD.
//  PAYLOAD: byte 0 first, each byte MSB-first. After 8*PAYLOAD_BYTES strobes -> TAIL.
//  TAIL: the next bit_en drives tx_out=0 and pulses tx_done for one cycle.
//   Also clears buf_count, tx_active=0, state -> IDLE.
//  Total: PREAMBLE_BITS+SYNC_BITS+8*PAYLOAD_BYTES data strobes + 1 tail strobe (97 at defaults).
//  Strobe spacing: any spacing >=1 cycle is valid; bit_en held high gives one bit per clock.
//  abort (any state, highest priority after rst): state=IDLE, tx_out=0, tx_active=0,
//   buf_count=0 at the next edge. No tx_done. A byte offered in the abort cycle is dropped
//   without an overflow pulse.
//  Counters: bit_cnt width $clog2(max(PREAMBLE_BITS,SYNC_BITS,8*PAYLOAD_BYTES)+1).
//   bit_cnt never wraps; it is reset on each state entry.
// TESTING
//  1. Assert rst mid-run -> tx_out=0, tx_active=0, buf_count=0, byte_ready=1 with no clock edge.
//  2. Load bytes 01..08, tx_start, bit_en every 4 clk -> tx_out = 1010x8, D391, 0102...08
//     (all MSB-first); tx_done pulses on strobe 97; byte_ready=1 afterwards.
//  3. Load 5 bytes, pulse tx_start -> tx_active stays 0, buf_count=5, tx_out=0.
//  4. Load 8 bytes, present a 9th (0xAA) -> overflow pulses once, buf_count=8,
//     and the transmitted payload excludes 0xAA.
//  5. abort at data strobe 40 (mid-payload) -> next cycle tx_out=0, tx_active=0,
//     buf_count=0; tx_done never pulses.
//  6. bit_en tied high -> full frame in 97 consecutive clocks, identical bit sequence to test 2.

Source files
------------

// File: rtl/pkt_tx_framer.sv
// pkt_tx_framer
//   Buffers PAYLOAD_BYTES bytes from the SPI slave byte stream, then on request
//   serializes preamble (1010...), sync word and payload MSB-first on tx_out,
//   one bit per bit_en strobe, followed by one tail strobe that ends the frame.
// Ports
//   clk, rst     system clock; asynchronous active-high reset
//   bit_en       1-cycle bit-period strobe
//   byte_in      payload byte, qualified by byte_valid
//   byte_ready   buffer can accept a byte this cycle (IDLE and not full)
//   tx_start     start transmission of a full buffer
//   abort        synchronous cancel of fill/transmit
//   tx_out       serial frame output, idle level 0
//   tx_active    high while a frame is in progress
//   tx_done      1-cycle pulse on normal frame completion
//   buf_count    bytes currently buffered
//   overflow     1-cycle pulse when a byte is offered while byte_ready=0
module pkt_tx_framer #(
  parameter int                        PREAMBLE_BITS = 16,
  parameter int                        SYNC_BITS     = 16,
  parameter logic [SYNC_BITS-1:0]      SYNC_WORD     = 16'hD391,
  parameter int                        PAYLOAD_BYTES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_en,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  input  logic       tx_start,
  input  logic       abort,
  output logic       tx_out,
  output logic       tx_active,
  output logic       tx_done,
  output logic [3:0] buf_count,
  output logic       overflow
);

  localparam int DATA_BITS = 8 * PAYLOAD_BYTES;
  localparam int MAX_HDR   = (PREAMBLE_BITS > SYNC_BITS) ? PREAMBLE_BITS : SYNC_BITS;
  localparam int MAX_BITS  = (MAX_HDR > DATA_BITS) ? MAX_HDR : DATA_BITS;
  localparam int CNT_W     = $clog2(MAX_BITS + 1);
  localparam int IDX_W     = $clog2(PAYLOAD_BYTES);
  localparam int SW_W      = $clog2(SYNC_BITS);

  localparam logic [3:0]       FULL      = 4'(PAYLOAD_BYTES);
  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PREAMBLE_BITS - 1);
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_BITS - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_SYNC,
    S_PAYLOAD,
    S_TAIL
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [7:0]       buf_mem [PAYLOAD_BYTES];

  logic [SW_W-1:0]  sync_idx;
  logic [IDX_W-1:0] byte_idx;
  logic [2:0]       bit_idx;
  logic             sync_bit;
  logic             payload_bit;

  assign byte_ready = (state == S_IDLE) && (buf_count < FULL);

  // Payload bit n is byte n/8, bit 7-(n%8); sync bit n is SYNC_WORD[SYNC_BITS-1-n].
  always_comb begin
    sync_idx    = SW_W'(SYNC_BITS - 1) - bit_cnt[SW_W-1:0];
    byte_idx    = bit_cnt[IDX_W+2:3];
    bit_idx     = ~bit_cnt[2:0];
    sync_bit    = SYNC_WORD[sync_idx];
    payload_bit = buf_mem[byte_idx][bit_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      buf_count <= '0;
      buf_mem   <= '{default: '0};
      tx_out    <= 1'b0;
      tx_active <= 1'b0;
      tx_done   <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      overflow <= 1'b0;
      if (abort) begin
        // Byte offered alongside abort is silently discarded.
        state     <= S_IDLE;
        bit_cnt   <= '0;
        buf_count <= '0;
        tx_out    <= 1'b0;
        tx_active <= 1'b0;
      end else begin
        if (byte_valid) begin
          if (byte_ready) begin
            buf_mem[buf_count[IDX_W-1:0]] <= byte_in;
            buf_count                     <= buf_count + 4'd1;
          end else begin
            overflow <= 1'b1;
          end
        end

        case (state)
          S_IDLE: begin
            tx_out <= 1'b0;
            // Uses the pre-write count, so a completing write cannot start a frame.
            if (tx_start && (buf_count == FULL)) begin
              state     <= S_PREAMBLE;
              bit_cnt   <= '0;
              tx_active <= 1'b1;
            end
          end
          S_PREAMBLE: if (bit_en) begin
            tx_out <= ~bit_cnt[0];
            if (bit_cnt == PRE_LAST) begin
              state   <= S_SYNC;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          S_SYNC: if (bit_en) begin
            tx_out <= sync_bit;
            if (bit_cnt == SYNC_LAST) begin
              state   <= S_PAYLOAD;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          S_PAYLOAD: if (bit_en) begin
            tx_out <= payload_bit;
            if (bit_cnt == DATA_LAST) begin
              state   <= S_TAIL;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          S_TAIL: if (bit_en) begin
            tx_out    <= 1'b0;
            tx_done   <= 1'b1;
            tx_active <= 1'b0;
            buf_count <= '0;
            state     <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pkt_tx_framer.sv
// tb_pkt_tx_framer
//   Scoreboard bench for pkt_tx_framer. The stimulus process keeps a byte-list
//   model of the buffer and, on each accepted start, pushes the whole expected
//   frame (bit value + done flag per strobe) into exp_q. The monitor pops one
//   entry for every strobe the framer should consume and compares.
module tb_pkt_tx_framer;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_en;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic       tx_start;
  logic       abort;
  logic       tx_out;
  logic       tx_active;
  logic       tx_done;
  logic [3:0] buf_count;
  logic       overflow;

  pkt_tx_framer #(
    .PREAMBLE_BITS(16),
    .SYNC_BITS    (16),
    .SYNC_WORD    (16'hD391),
    .PAYLOAD_BYTES(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bit_en    (bit_en),
    .byte_in   (byte_in),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .tx_start  (tx_start),
    .abort     (abort),
    .tx_out    (tx_out),
    .tx_active (tx_active),
    .tx_done   (tx_done),
    .buf_count (buf_count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic b;
    logic d;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mdl_buf[$];
  int         vectors     = 0;
  int         miscompares = 0;
  int         mode        = 0;  // 0: strobe every 4 clk, 1: tied high, 2: random

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // bit_en generator
  initial begin
    int unsigned cnt = 0;
    bit_en = 1'b0;
    forever begin
      tick();
      cnt++;
      case (mode)
        0:       bit_en = (cnt % 4 == 0);
        1:       bit_en = 1'b1;
        default: bit_en = ($urandom % 3 == 0);
      endcase
    end
  end

  // Monitor: inputs sampled mid-cycle, outputs checked 1 ns after the edge.
  initial begin
    logic s_en, s_abort, s_rst, s_pending;
    exp_t e;
    forever begin
      @(negedge clk);
      s_en      = bit_en;
      s_abort   = abort;
      s_rst     = rst;
      s_pending = (exp_q.size() > 0);
      @(posedge clk);
      #1;
      if (s_rst) begin
      end else if (s_en && !s_abort && s_pending) begin
        e = exp_q.pop_front();
        chk("tx_out_bit", 32'(tx_out), 32'(e.b));
        chk("tx_done_bit", 32'(tx_done), 32'(e.d));
      end else begin
        chk("tx_done_quiet", 32'(tx_done), 0);
        if (!s_pending) chk("tx_out_idle", 32'(tx_out), 0);
      end
    end
  end

  task automatic push_byte(input logic [7:0] b);
    logic exp_ov;
    exp_ov     = (mdl_buf.size() >= 8);
    byte_valid = 1'b1;
    byte_in    = b;
    if (!exp_ov) mdl_buf.push_back(b);
    tick();
    byte_valid = 1'b0;
    chk("overflow", 32'(overflow), 32'(exp_ov));
    chk("buf_count", 32'(buf_count), mdl_buf.size());
  endtask

  task automatic load_bytes(input int n, input logic [7:0] base, input bit rnd);
    for (int i = 0; i < n; i++) push_byte(rnd ? 8'($urandom) : base + 8'(i));
  endtask

  function automatic void push_exp(input logic b, input logic d);
    exp_t e;
    e.b = b;
    e.d = d;
    exp_q.push_back(e);
  endfunction

  // Expected frame straight from the frame format definition.
  function automatic void build_frame();
    logic [15:0] sw;
    logic [7:0]  by;
    sw = 16'hD391;
    for (int i = 0; i < 16; i++) push_exp((i % 2) == 0, 1'b0);
    for (int i = 0; i < 16; i++) push_exp(sw[15-i], 1'b0);
    for (int k = 0; k < 8; k++) begin
      by = mdl_buf[k];
      for (int j = 7; j >= 0; j--) push_exp(by[j], 1'b0);
    end
    push_exp(1'b0, 1'b1);
  endfunction

  task automatic start_frame();
    logic full;
    full     = (mdl_buf.size() == 8);
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    if (full) build_frame();
    chk("tx_active_start", 32'(tx_active), 32'(full));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_tx_out", 32'(tx_out), 0);
    chk("rst_tx_active", 32'(tx_active), 0);
    chk("rst_buf_count", 32'(buf_count), 0);
    chk("rst_byte_ready", 32'(byte_ready), 1);
    exp_q.delete();
    mdl_buf.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_frame(output int n);
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL frame_timeout: %0d bits left, expected 0", exp_q.size());
      do_reset();
    end
    mdl_buf.delete();
    chk("end_tx_active", 32'(tx_active), 0);
    chk("end_buf_count", 32'(buf_count), 0);
    chk("end_byte_ready", 32'(byte_ready), 1);
    chk("end_tx_out", 32'(tx_out), 0);
  endtask

  initial begin
    int n;
    rst        = 1'b1;
    byte_in    = '0;
    byte_valid = 1'b0;
    tx_start   = 1'b0;
    abort      = 1'b0;
    #1;
    chk("init_tx_out", 32'(tx_out), 0);
    chk("init_tx_active", 32'(tx_active), 0);
    chk("init_tx_done", 32'(tx_done), 0);
    chk("init_overflow", 32'(overflow), 0);
    chk("init_buf_count", 32'(buf_count), 0);
    chk("init_byte_ready", 32'(byte_ready), 1);
    tick();
    tick();
    rst = 1'b0;

    // Bytes 01..08, strobe every 4 clocks.
    mode = 0;
    load_bytes(8, 8'h01, 1'b0);
    chk("full_byte_ready", 32'(byte_ready), 0);
    start_frame();
    wait_frame(n);

    // Short buffer: start ignored; then start coinciding with completing write.
    load_bytes(5, 8'h10, 1'b0);
    start_frame();
    tick();
    chk("short_tx_active", 32'(tx_active), 0);
    chk("short_buf_count", 32'(buf_count), 5);
    chk("short_tx_out", 32'(tx_out), 0);
    load_bytes(2, 8'h15, 1'b0);
    byte_valid = 1'b1;
    byte_in    = 8'h17;
    tx_start   = 1'b1;
    mdl_buf.push_back(8'h17);
    tick();
    byte_valid = 1'b0;
    tx_start   = 1'b0;
    tick();
    chk("same_cycle_tx_active", 32'(tx_active), 0);
    chk("same_cycle_buf_count", 32'(buf_count), 8);

    // Ninth byte while full: dropped with a single overflow pulse.
    push_byte(8'hAA);
    tick();
    chk("overflow_once", 32'(overflow), 0);
    start_frame();
    wait_frame(n);

    // Abort at data strobe 40, with a byte offered in the abort cycle.
    load_bytes(8, 8'h00, 1'b1);
    start_frame();
    n = 0;
    while (exp_q.size() > 57 && n < 1000) begin
      tick();
      n++;
    end
    abort      = 1'b1;
    byte_valid = 1'b1;
    byte_in    = 8'h55;
    tick();
    abort      = 1'b0;
    byte_valid = 1'b0;
    exp_q.delete();
    mdl_buf.delete();
    chk("abort_tx_out", 32'(tx_out), 0);
    chk("abort_tx_active", 32'(tx_active), 0);
    chk("abort_buf_count", 32'(buf_count), 0);
    chk("abort_overflow", 32'(overflow), 0);
    chk("abort_byte_ready", 32'(byte_ready), 1);
    repeat (6) tick();

    // bit_en tied high: 97 consecutive clocks, same frame as the first test.
    mode = 1;
    load_bytes(8, 8'h01, 1'b0);
    start_frame();
    wait_frame(n);
    chk("tied_high_clocks", n, 97);

    // Asynchronous reset mid-frame while tx_out is high.
    mode = 0;
    load_bytes(8, 8'h00, 1'b1);
    start_frame();
    n = 0;
    while (exp_q.size() > 96 && n < 100) begin
      tick();
      n++;
    end
    chk("pre_rst_tx_out", 32'(tx_out), 1);
    do_reset();

    // Random payloads with irregular strobe spacing.
    mode = 2;
    for (int f = 0; f < 4; f++) begin
      load_bytes(8, 8'h00, 1'b1);
      start_frame();
      wait_frame(n);
    end

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
